weight_rotator_ctrl: RTL

- Controller directly upstream of two cyclic_bram instances (ping-pong banks A=0, B=1).
- Fills one bank from the weight AXI-stream while the other bank is read cyclically (wrap r_max→r_min) for a configured number of passes.
- Re-times BRAM read data into a valid/ready/last stream for the PE array.
- Owns every cyclic_bram control input: clken, resetn_local, w_en, r_en, r_addr_max/min, s_data.

---
 rtl/weight_rotator_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/weight_rotator_ctrl.sv
// weight_rotator_ctrl
//   Ping-pong controller for two cyclic_bram banks (A=0, B=1). One bank is
//   filled from the weight stream while the other is read cyclically
//   (0..r_max on the first pass, then r_min..r_max) for a configured number of
//   passes. Read data is re-timed into a valid/ready/last stream.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   s_cfg_*                      per-tile config (r_max, r_min, repeats)
//   s_valid/s_ready/s_data/s_last  weight fill stream
//   bram_*                       control and data for both banks (bank b at bit/slice b)
//   m_valid/m_ready/m_data/m_last  re-timed output stream
module weight_rotator_ctrl #(
  parameter int unsigned R_DEPTH      = 8,
  parameter int unsigned R_DATA_WIDTH = 8,
  parameter int unsigned W_DATA_WIDTH = 8,
  parameter int unsigned LATENCY      = 3,
  parameter int unsigned R_ADDR_WIDTH = $clog2(R_DEPTH),
  parameter int unsigned REP_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_cfg_valid,
  output logic                      s_cfg_ready,
  input  logic [R_ADDR_WIDTH-1:0]   s_cfg_r_max,
  input  logic [R_ADDR_WIDTH-1:0]   s_cfg_r_min,
  input  logic [REP_WIDTH-1:0]      s_cfg_repeats,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [W_DATA_WIDTH-1:0]   s_data,
  input  logic                      s_last,
  output logic [1:0]                bram_clken,
  output logic [1:0]                bram_resetn_local,
  output logic [1:0]                bram_w_en,
  output logic [1:0]                bram_r_en,
  output logic [W_DATA_WIDTH-1:0]   bram_s_data,
  output logic [2*R_ADDR_WIDTH-1:0] bram_r_addr_max,
  output logic [2*R_ADDR_WIDTH-1:0] bram_r_addr_min,
  input  logic [2*R_DATA_WIDTH-1:0] bram_m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [R_DATA_WIDTH-1:0]   m_data,
  output logic                      m_last
);

  typedef enum logic [2:0] {
    ST_EMPTY,
    ST_FILLING,
    ST_FULL,
    ST_READING,
    ST_DRAINING
  } bank_state_t;

  bank_state_t state_q [2];
  bank_state_t state_d [2];

  logic                    wp, rp;
  logic [R_ADDR_WIDTH-1:0] rmax_q [2];
  logic [R_ADDR_WIDTH-1:0] rmin_q [2];
  logic [REP_WIDTH-1:0]    reps_q [2];

  // Shadow of the reading bank's internal address counter
  logic [R_ADDR_WIDTH-1:0] rd_addr;
  logic [REP_WIDTH-1:0]    rd_pass;

  logic [1:0]              w_en_q;
  logic [1:0]              rst_pulse;
  logic [W_DATA_WIDTH-1:0] s_data_q;

  logic [LATENCY-1:0]      pipe_valid;
  logic [LATENCY-1:0]      pipe_bank;
  logic [LATENCY-1:0]      pipe_last;

  logic adv, cfg_fire, beat_fire, rd_issue, rd_wrap, rd_last_pass, rd_final;
  logic done_fire, done_bank;

  assign m_valid   = pipe_valid[LATENCY-1];
  assign m_last    = pipe_last[LATENCY-1];
  assign done_bank = pipe_bank[LATENCY-1];
  assign adv       = m_ready | ~m_valid;

  // A bank that just finished is held off config for its reset cycle
  assign s_cfg_ready = ~rst & (state_q[wp] == ST_EMPTY) & ~rst_pulse[wp];
  assign s_ready     = (state_q[wp] == ST_FILLING);
  assign cfg_fire    = s_cfg_valid & s_cfg_ready;
  assign beat_fire   = s_valid & s_ready;

  assign rd_issue     = (state_q[rp] == ST_READING) & adv;
  assign rd_wrap      = (rd_addr == rmax_q[rp]);
  assign rd_last_pass = ({1'b0, rd_pass} + (REP_WIDTH+1)'(1)) >= {1'b0, reps_q[rp]};
  assign rd_final     = rd_issue & rd_wrap & rd_last_pass;

  assign done_fire = m_valid & m_ready & m_last;

  always_comb begin
    for (int unsigned b = 0; b < 2; b++) begin
      state_d[b] = state_q[b];
      unique case (state_q[b])
        ST_EMPTY:    if (cfg_fire && wp == 1'(b)) state_d[b] = ST_FILLING;
        ST_FILLING:  if (beat_fire && s_last && wp == 1'(b)) state_d[b] = ST_FULL;
        // Also start when the other bank issues its final read, so the
        // hand-over between tiles has no bubble
        ST_FULL:     if (rp == 1'(b) || rd_final) state_d[b] = ST_READING;
        ST_READING:  if (rd_final && rp == 1'(b)) state_d[b] = ST_DRAINING;
        ST_DRAINING: if (done_fire && done_bank == 1'(b)) state_d[b] = ST_EMPTY;
        default:     state_d[b] = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned b = 0; b < 2; b++) begin
        state_q[b] <= ST_EMPTY;
        rmax_q[b]  <= '0;
        rmin_q[b]  <= '0;
        reps_q[b]  <= '0;
      end
      wp         <= 1'b0;
      rp         <= 1'b0;
      rd_addr    <= '0;
      rd_pass    <= '0;
      w_en_q     <= '0;
      rst_pulse  <= '0;
      s_data_q   <= '0;
      pipe_valid <= '0;
      pipe_bank  <= '0;
      pipe_last  <= '0;
    end else begin
      state_q <= state_d;

      if (cfg_fire) begin
        rmax_q[wp] <= s_cfg_r_max;
        rmin_q[wp] <= s_cfg_r_min;
        reps_q[wp] <= s_cfg_repeats;
      end

      w_en_q <= beat_fire ? (2'b01 << wp) : 2'b00;
      if (beat_fire) begin
        s_data_q <= s_data;
        if (s_last) wp <= ~wp;
      end

      if (rd_issue) begin
        if (rd_final) begin
          rd_addr <= '0;
          rd_pass <= '0;
          rp      <= ~rp;
        end else if (rd_wrap) begin
          rd_addr <= rmin_q[rp];
          rd_pass <= rd_pass + REP_WIDTH'(1);
        end else begin
          rd_addr <= rd_addr + R_ADDR_WIDTH'(1);
        end
      end

      // Tag pipeline moves in lock-step with the BRAM read pipeline (same clken)
      if (adv) begin
        pipe_valid[0] <= rd_issue;
        pipe_bank[0]  <= rp;
        pipe_last[0]  <= rd_final;
        for (int unsigned i = 1; i < LATENCY; i++) begin
          pipe_valid[i] <= pipe_valid[i-1];
          pipe_bank[i]  <= pipe_bank[i-1];
          pipe_last[i]  <= pipe_last[i-1];
        end
      end

      rst_pulse <= done_fire ? (2'b01 << done_bank) : 2'b00;
    end
  end

  always_comb begin
    bram_clken = '1;
    bram_r_en  = '0;
    for (int unsigned b = 0; b < 2; b++) begin
      // Banks with reads in flight must stall with the output pipeline
      if (state_q[b] == ST_READING || state_q[b] == ST_DRAINING) bram_clken[b] = adv;
      if (rd_issue && rp == 1'(b)) bram_r_en[b] = 1'b1;
    end
  end

  assign bram_w_en         = w_en_q;
  assign bram_s_data       = s_data_q;
  assign bram_resetn_local = rst ? 2'b00 : ~rst_pulse;
  assign bram_r_addr_max   = {rmax_q[1], rmax_q[0]};
  assign bram_r_addr_min   = {rmin_q[1], rmin_q[0]};

  assign m_data = !m_valid ? '0
                : (done_bank ? bram_m_data[2*R_DATA_WIDTH-1:R_DATA_WIDTH]
                             : bram_m_data[R_DATA_WIDTH-1:0]);

endmodule
